// File: rtl/axi4_ram_slave.sv
// AXI4 slave backed by a byte-writable 128-bit register-array RAM.
// Serves one transaction at a time; write and read address channels share a round-robin arbiter.
module axi4_ram_slave #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         slaveAxi_aw_valid,
  output logic         slaveAxi_aw_ready,
  input  logic [31:0]  slaveAxi_aw_payload_addr,
  input  logic [7:0]   slaveAxi_aw_payload_len,
  input  logic [2:0]   slaveAxi_aw_payload_size,
  input  logic [1:0]   slaveAxi_aw_payload_burst,
  input  logic         slaveAxi_w_valid,
  output logic         slaveAxi_w_ready,
  input  logic [127:0] slaveAxi_w_payload_data,
  input  logic [15:0]  slaveAxi_w_payload_strb,
  input  logic         slaveAxi_w_payload_last,
  output logic         slaveAxi_b_valid,
  input  logic         slaveAxi_b_ready,
  output logic [1:0]   slaveAxi_b_payload_resp,
  input  logic         slaveAxi_ar_valid,
  output logic         slaveAxi_ar_ready,
  input  logic [31:0]  slaveAxi_ar_payload_addr,
  input  logic [7:0]   slaveAxi_ar_payload_len,
  input  logic [2:0]   slaveAxi_ar_payload_size,
  input  logic [1:0]   slaveAxi_ar_payload_burst,
  output logic         slaveAxi_r_valid,
  input  logic         slaveAxi_r_ready,
  output logic [127:0] slaveAxi_r_payload_data,
  output logic [1:0]   slaveAxi_r_payload_resp,
  output logic         slaveAxi_r_payload_last
);

  localparam int unsigned IW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 16);
  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t       state;
  logic [31:0]  addr_q;
  logic [7:0]   len_q;
  logic [7:0]   beat_q;
  logic [2:0]   size_q;
  logic [1:0]   burst_q;
  logic         aerr_q;
  logic         err_q;
  logic         prio_read;

  logic [127:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE_ADDR) < MEM_BYTES;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 4);
  endfunction

  logic          aw_hs, w_hs, ar_hs;
  logic          grant_w, grant_r;
  logic          aw_aerr, ar_aerr;
  logic          last_beat, w_err_now, mem_we;
  logic          rd0_bad, rdn_bad;
  logic [31:0]   next_addr;
  logic [127:0]  rd0_data, rdn_data;

  always_comb begin
    aw_hs     = slaveAxi_aw_valid & slaveAxi_aw_ready;
    w_hs      = slaveAxi_w_valid & slaveAxi_w_ready;
    ar_hs     = slaveAxi_ar_valid & slaveAxi_ar_ready;
    // prio_read breaks ties only; a lone requester always wins
    grant_w   = slaveAxi_aw_valid & (~slaveAxi_ar_valid | ~prio_read);
    grant_r   = slaveAxi_ar_valid & (~slaveAxi_aw_valid | prio_read);
    aw_aerr   = slaveAxi_aw_payload_burst[1] | (slaveAxi_aw_payload_size > 3'd4);
    ar_aerr   = slaveAxi_ar_payload_burst[1] | (slaveAxi_ar_payload_size > 3'd4);
    next_addr = (burst_q == 2'b01) ? addr_q + (32'd1 << size_q) : addr_q;
    last_beat = (beat_q == len_q);
    w_err_now = ~in_range(addr_q) | (slaveAxi_w_payload_last != last_beat);
    mem_we    = (state == WDATA) & w_hs & in_range(addr_q) & ~aerr_q;
    rd0_bad   = ar_aerr | ~in_range(slaveAxi_ar_payload_addr);
    rdn_bad   = aerr_q | err_q | ~in_range(next_addr);
    rd0_data  = rd0_bad ? '0 : mem[word_idx(slaveAxi_ar_payload_addr)];
    rdn_data  = rdn_bad ? '0 : mem[word_idx(next_addr)];
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (slaveAxi_w_payload_strb[i])
          mem[word_idx(addr_q)][8*i +: 8] <= slaveAxi_w_payload_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                   <= IDLE;
      addr_q                  <= '0;
      len_q                   <= '0;
      beat_q                  <= '0;
      size_q                  <= '0;
      burst_q                 <= '0;
      aerr_q                  <= 1'b0;
      err_q                   <= 1'b0;
      prio_read               <= 1'b0;
      slaveAxi_aw_ready       <= 1'b0;
      slaveAxi_ar_ready       <= 1'b0;
      slaveAxi_w_ready        <= 1'b0;
      slaveAxi_b_valid        <= 1'b0;
      slaveAxi_b_payload_resp <= OKAY;
      slaveAxi_r_valid        <= 1'b0;
      slaveAxi_r_payload_data <= '0;
      slaveAxi_r_payload_resp <= OKAY;
      slaveAxi_r_payload_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            addr_q            <= slaveAxi_aw_payload_addr;
            len_q             <= slaveAxi_aw_payload_len;
            size_q            <= slaveAxi_aw_payload_size;
            burst_q           <= slaveAxi_aw_payload_burst;
            beat_q            <= '0;
            aerr_q            <= aw_aerr;
            err_q             <= 1'b0;
            prio_read         <= 1'b1;
            slaveAxi_aw_ready <= 1'b0;
            slaveAxi_ar_ready <= 1'b0;
            slaveAxi_w_ready  <= 1'b1;
            state             <= WDATA;
          end else if (ar_hs) begin
            addr_q                  <= slaveAxi_ar_payload_addr;
            len_q                   <= slaveAxi_ar_payload_len;
            size_q                  <= slaveAxi_ar_payload_size;
            burst_q                 <= slaveAxi_ar_payload_burst;
            beat_q                  <= '0;
            aerr_q                  <= ar_aerr;
            err_q                   <= rd0_bad;
            prio_read               <= 1'b0;
            slaveAxi_aw_ready       <= 1'b0;
            slaveAxi_ar_ready       <= 1'b0;
            slaveAxi_r_valid        <= 1'b1;
            slaveAxi_r_payload_data <= rd0_data;
            slaveAxi_r_payload_resp <= rd0_bad ? SLVERR : OKAY;
            slaveAxi_r_payload_last <= (slaveAxi_ar_payload_len == 8'd0);
            state                   <= RDATA;
          end else begin
            slaveAxi_aw_ready <= grant_w;
            slaveAxi_ar_ready <= grant_r;
          end
        end

        WDATA: begin
          if (w_hs) begin
            if (w_err_now) err_q <= 1'b1;
            if (last_beat) begin
              slaveAxi_w_ready        <= 1'b0;
              slaveAxi_b_valid        <= 1'b1;
              slaveAxi_b_payload_resp <= (aerr_q | err_q | w_err_now) ? SLVERR : OKAY;
              state                   <= WRESP;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= next_addr;
            end
          end
        end

        WRESP: begin
          if (slaveAxi_b_ready) begin
            slaveAxi_b_valid        <= 1'b0;
            slaveAxi_b_payload_resp <= OKAY;
            slaveAxi_aw_ready       <= grant_w;
            slaveAxi_ar_ready       <= grant_r;
            state                   <= IDLE;
          end
        end

        RDATA: begin
          if (slaveAxi_r_ready) begin
            if (slaveAxi_r_payload_last) begin
              slaveAxi_r_valid        <= 1'b0;
              slaveAxi_r_payload_last <= 1'b0;
              slaveAxi_aw_ready       <= grant_w;
              slaveAxi_ar_ready       <= grant_r;
              state                   <= IDLE;
            end else begin
              // next beat is presented on the same edge that retires the current one
              beat_q                  <= beat_q + 8'd1;
              addr_q                  <= next_addr;
              err_q                   <= rdn_bad;
              slaveAxi_r_payload_data <= rdn_data;
              slaveAxi_r_payload_resp <= rdn_bad ? SLVERR : OKAY;
              slaveAxi_r_payload_last <= ((beat_q + 8'd1) == len_q);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_ram_slave.sv
// Directed bench for axi4_ram_slave: write/read, bursts with backpressure, strobes,
// arbitration, error responses and reset in the middle of a burst.
module tb_axi4_ram_slave;
  logic         clk = 1'b0;
  logic         reset;
  logic         aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic         ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [31:0]  aw_addr, ar_addr;
  logic [7:0]   aw_len, ar_len;
  logic [2:0]   aw_size, ar_size;
  logic [1:0]   aw_burst, ar_burst, b_resp, r_resp;
  logic [127:0] w_data, r_data;
  logic [15:0]  w_strb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi4_ram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .slaveAxi_aw_valid(aw_valid), .slaveAxi_aw_ready(aw_ready),
    .slaveAxi_aw_payload_addr(aw_addr), .slaveAxi_aw_payload_len(aw_len),
    .slaveAxi_aw_payload_size(aw_size), .slaveAxi_aw_payload_burst(aw_burst),
    .slaveAxi_w_valid(w_valid), .slaveAxi_w_ready(w_ready),
    .slaveAxi_w_payload_data(w_data), .slaveAxi_w_payload_strb(w_strb),
    .slaveAxi_w_payload_last(w_last),
    .slaveAxi_b_valid(b_valid), .slaveAxi_b_ready(b_ready),
    .slaveAxi_b_payload_resp(b_resp),
    .slaveAxi_ar_valid(ar_valid), .slaveAxi_ar_ready(ar_ready),
    .slaveAxi_ar_payload_addr(ar_addr), .slaveAxi_ar_payload_len(ar_len),
    .slaveAxi_ar_payload_size(ar_size), .slaveAxi_ar_payload_burst(ar_burst),
    .slaveAxi_r_valid(r_valid), .slaveAxi_r_ready(r_ready),
    .slaveAxi_r_payload_data(r_data), .slaveAxi_r_payload_resp(r_resp),
    .slaveAxi_r_payload_last(r_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b);
    int n = 0;
    aw_addr = a; aw_len = l; aw_size = s; aw_burst = b; aw_valid = 1'b1;
    while (!aw_ready && n < 40) begin tick(); n++; end
    chk("aw_ready_wait", aw_ready, 1);
    tick();
    aw_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b);
    int n = 0;
    ar_addr = a; ar_len = l; ar_size = s; ar_burst = b; ar_valid = 1'b1;
    while (!ar_ready && n < 40) begin tick(); n++; end
    chk("ar_ready_wait", ar_ready, 1);
    tick();
    ar_valid = 1'b0;
  endtask

  task automatic w_send(input logic [127:0] d, input logic [15:0] s, input logic l);
    int n = 0;
    w_data = d; w_strb = s; w_last = l; w_valid = 1'b1;
    while (!w_ready && n < 40) begin tick(); n++; end
    chk("w_ready_wait", w_ready, 1);
    tick();
    w_valid = 1'b0;
  endtask

  task automatic b_recv(input logic [1:0] exp_resp);
    int n = 0;
    b_ready = 1'b1;
    while (!b_valid && n < 40) begin tick(); n++; end
    chk("b_valid_wait", b_valid, 1);
    chk("b_resp", b_resp, exp_resp);
    tick();
    b_ready = 1'b0;
  endtask

  task automatic r_recv(input logic [127:0] d, input logic [1:0] rs, input logic l, input logic stall);
    int n = 0;
    r_ready = !stall;
    while (!r_valid && n < 40) begin tick(); n++; end
    chk("r_valid_wait", r_valid, 1);
    if (stall) begin
      chk("r_data_pre_stall", r_data, d);
      tick();
      chk("r_data_stalled", r_data, d);
      chk("r_last_stalled", r_last, l);
      chk("r_valid_stalled", r_valid, 1);
      r_ready = 1'b1;
    end
    chk("r_data", r_data, d);
    chk("r_resp", r_resp, rs);
    chk("r_last", r_last, l);
    tick();
    r_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    aw_valid = 0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    w_valid = 0; w_data = '0; w_strb = '0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; r_ready = 0;

    // reset values
    repeat (3) tick();
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_resp", b_resp, 0);
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_r_resp", r_resp, 0);
    chk("rst_r_last", r_last, 0);
    reset = 1'b1;
    tick();

    // arbitration: simultaneous AW/AR -> write first, then read wins the next contention
    aw_addr = 32'h0; aw_len = 0; aw_size = 3'd4; aw_burst = 2'b01; aw_valid = 1'b1;
    ar_addr = 32'h0; ar_len = 0; ar_size = 3'd4; ar_burst = 2'b01; ar_valid = 1'b1;
    n = 0;
    while (!(aw_ready || ar_ready) && n < 40) begin tick(); n++; end
    chk("arb1_aw_ready", aw_ready, 1);
    chk("arb1_ar_ready", ar_ready, 0);
    tick();
    aw_addr = 32'h300;
    chk("aw_to_w_ready", w_ready, 1);
    chk("wdata_aw_ready_low", aw_ready, 0);
    w_send(128'hA0A0_0000_1111_2222_3333_4444_5555_6666, 16'hFFFF, 1'b1);
    chk("b_valid_after_last_w", b_valid, 1);
    chk("wresp_ar_ready_low", ar_ready, 0);
    chk("wresp_aw_ready_low", aw_ready, 0);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("arb2_ar_ready", ar_ready, 1);
    chk("arb2_aw_ready", aw_ready, 0);
    tick();
    ar_valid = 1'b0;
    r_recv(128'hA0A0_0000_1111_2222_3333_4444_5555_6666, 2'b00, 1'b1, 1'b0);
    aw_send(32'h300, 8'd0, 3'd4, 2'b01);
    w_send(128'hA1A1_7777_8888_9999_AAAA_BBBB_CCCC_DDDD, 16'hFFFF, 1'b1);
    b_recv(2'b00);

    // single write then read
    aw_send(32'h10, 8'd0, 3'd4, 2'b01);
    w_send(128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 16'hFFFF, 1'b1);
    b_recv(2'b00);
    ar_send(32'h10, 8'd0, 3'd4, 2'b01);
    r_recv(128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 2'b00, 1'b1, 1'b0);

    // INCR burst with w_valid toggling, read back with r_ready stalls
    aw_send(32'h100, 8'd3, 3'd4, 2'b01);
    w_send(128'h1000_0000_0000_0000_0000_0000_0000_0001, 16'hFFFF, 1'b0);
    tick();
    w_send(128'h2000_0000_0000_0000_0000_0000_0000_0002, 16'hFFFF, 1'b0);
    tick();
    w_send(128'h3000_0000_0000_0000_0000_0000_0000_0003, 16'hFFFF, 1'b0);
    tick();
    w_send(128'h4000_0000_0000_0000_0000_0000_0000_0004, 16'hFFFF, 1'b1);
    b_recv(2'b00);
    ar_send(32'h100, 8'd3, 3'd4, 2'b01);
    r_recv(128'h1000_0000_0000_0000_0000_0000_0000_0001, 2'b00, 1'b0, 1'b0);
    r_recv(128'h2000_0000_0000_0000_0000_0000_0000_0002, 2'b00, 1'b0, 1'b1);
    r_recv(128'h3000_0000_0000_0000_0000_0000_0000_0003, 2'b00, 1'b0, 1'b0);
    r_recv(128'h4000_0000_0000_0000_0000_0000_0000_0004, 2'b00, 1'b1, 1'b1);

    // strobe / narrow write
    aw_send(32'h200, 8'd0, 3'd4, 2'b01);
    w_send({128{1'b1}}, 16'hFFFF, 1'b1);
    b_recv(2'b00);
    aw_send(32'h203, 8'd0, 3'd0, 2'b01);
    w_send(128'h0000_0000_0000_0000_0000_0000_5A00_0000, 16'h0008, 1'b1);
    b_recv(2'b00);
    ar_send(32'h200, 8'd0, 3'd4, 2'b01);
    r_recv(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_5AFF_FFFF, 2'b00, 1'b1, 1'b0);

    // burst running off the end of memory
    aw_send(32'h3FF0, 8'd1, 3'd4, 2'b01);
    w_send(128'hE0E0_E0E0_E0E0_E0E0_E0E0_E0E0_E0E0_E0E0, 16'hFFFF, 1'b0);
    w_send(128'hE1E1_E1E1_E1E1_E1E1_E1E1_E1E1_E1E1_E1E1, 16'hFFFF, 1'b1);
    b_recv(2'b10);
    ar_send(32'h0, 8'd0, 3'd4, 2'b01);
    r_recv(128'hA0A0_0000_1111_2222_3333_4444_5555_6666, 2'b00, 1'b1, 1'b0);
    ar_send(32'h3FF0, 8'd1, 3'd4, 2'b01);
    r_recv(128'hE0E0_E0E0_E0E0_E0E0_E0E0_E0E0_E0E0_E0E0, 2'b00, 1'b0, 1'b0);
    r_recv(128'h0, 2'b10, 1'b1, 1'b0);

    // WRAP burst read is rejected beat by beat
    ar_send(32'h10, 8'd1, 3'd4, 2'b10);
    r_recv(128'h0, 2'b10, 1'b0, 1'b0);
    r_recv(128'h0, 2'b10, 1'b1, 1'b0);

    // early w_last
    aw_send(32'h400, 8'd1, 3'd4, 2'b01);
    w_send(128'h4444, 16'hFFFF, 1'b1);
    w_send(128'h5555, 16'hFFFF, 1'b1);
    b_recv(2'b10);

    // reset in the middle of a write burst
    aw_send(32'h500, 8'd3, 3'd4, 2'b01);
    w_send(128'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0, 16'hFFFF, 1'b0);
    w_send(128'hC1C1_C1C1_C1C1_C1C1_C1C1_C1C1_C1C1_C1C1, 16'hFFFF, 1'b0);
    chk("pre_reset_w_ready", w_ready, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_aw_ready", aw_ready, 0);
    chk("mid_rst_w_ready", w_ready, 0);
    chk("mid_rst_b_valid", b_valid, 0);
    chk("mid_rst_b_resp", b_resp, 0);
    chk("mid_rst_ar_ready", ar_ready, 0);
    chk("mid_rst_r_valid", r_valid, 0);
    chk("mid_rst_r_data", r_data, 0);
    chk("mid_rst_r_resp", r_resp, 0);
    chk("mid_rst_r_last", r_last, 0);
    tick();
    tick();
    reset = 1'b1;
    aw_addr = 32'h520; aw_len = 0; aw_size = 3'd4; aw_burst = 2'b01; aw_valid = 1'b1;
    tick();
    chk("post_rst_aw_ready", aw_ready, 1);
    aw_send(32'h520, 8'd0, 3'd4, 2'b01);
    w_send(128'hD0D0_D0D0_D0D0_D0D0_D0D0_D0D0_D0D0_D0D0, 16'hFFFF, 1'b1);
    b_recv(2'b00);
    ar_send(32'h500, 8'd1, 3'd4, 2'b01);
    r_recv(128'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0, 2'b00, 1'b0, 1'b0);
    r_recv(128'hC1C1_C1C1_C1C1_C1C1_C1C1_C1C1_C1C1_C1C1, 2'b00, 1'b1, 1'b0);
    ar_send(32'h520, 8'd0, 3'd4, 2'b01);
    r_recv(128'hD0D0_D0D0_D0D0_D0D0_D0D0_D0D0_D0D0_D0D0, 2'b00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_ram_slave.md
# axi4_ram_slave

AXI4 slave memory model that terminates the 128-bit AXI4 master port driven by the DPI/TCP bridge master. It is the downstream stage that consumes the master's AW/W/B/AR/R channels and backs them with a byte-writable register-array RAM. It lets socket-driven tests run full read/write bursts with no external model. It serves one transaction at a time and arbitrates fairly between the write and read channels.

## Interface
- MEM_WORDS, 1024: RAM depth in 128-bit words; valid byte range is 0 .. MEM_WORDS*16-1.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserts immediately when low, released synchronously to clk by the system).
- slaveAxi_aw_valid / aw_ready  in / out  1 / 1  write-address handshake.
- slaveAxi_aw_payload_addr / len / size / burst  in  32 / 8 / 3 / 2  write-address payload.
- slaveAxi_w_valid / w_ready  in / out  1 / 1  write-data handshake.
- slaveAxi_w_payload_data / strb / last  in  128 / 16 / 1  write-data payload.
- slaveAxi_b_valid / b_ready  out / in  1 / 1  write-response handshake.
- slaveAxi_b_payload_resp  out  2  write response.
- slaveAxi_ar_valid / ar_ready  in / out  1 / 1  read-address handshake.
- slaveAxi_ar_payload_addr / len / size / burst  in  32 / 8 / 3 / 2  read-address payload.
- slaveAxi_r_valid / r_ready  out / in  1 / 1  read-data handshake.
- slaveAxi_r_payload_data / resp / last  out  128 / 2 / 1  read-data payload.

## Operation
- FSM states: IDLE, WDATA, WRESP, RDATA. Reset state: IDLE.
- IDLE drives aw_ready=1 and ar_ready=1 only when the arbiter selects that channel. Only one of them is high in any cycle.
- Arbitration:
  - Only AW valid: grant write. Only AR valid: grant read.
  - Both valid: round-robin. The first grant after reset goes to write; afterwards the channel that lost last time wins.
- On an AW or AR handshake, latch addr, len, size and burst. Clear the beat counter and the error flag. Move to WDATA or RDATA.
- Beat address:
  - Beat 0 uses the latched addr.
  - INCR (01): each following beat adds 1<<size to the previous beat address. The sum is 32-bit and wraps modulo 2^32.
  - FIXED (00): the address stays constant.
- Word index = (beat_addr - BASE_ADDR) >> 4. Narrow sizes address the full 128-bit word; the master's strb selects the lanes.
- Errors (resp = SLVERR, 2'b10). Each raises the sticky error flag for the current transaction:
  - burst 2'b10 or 2'b11;
  - size > 4;
  - beat address outside the valid range;
  - on a write, w_last does not match (beat == len).
- WDATA: w_ready=1.
  - Each W handshake writes the bytes whose strb bit is set.
  - No write occurs if the beat address is out of range or the error flag is already set from the address phase.
  - The beat counter increments on each handshake.
  - The handshake at beat == len moves the FSM to WRESP, whatever w_last says.
- WRESP: b_valid=1 with resp OKAY (00), or SLVERR if the error flag is set. Hold until b_ready, then go to IDLE.
- RDATA:
  - r_data/r_resp/r_last are registered. Beat 0 loads on AR acceptance.
  - Each R handshake loads the next beat on the same edge.
  - r_last=1 exactly on beat len.
  - An out-of-range or erroneous beat returns data 0 and resp SLVERR.
  - The handshake with r_last moves the FSM to IDLE.

## Timing
- Reset values: aw_ready=0, w_ready=0, b_valid=0, b_resp=0, ar_ready=0, r_valid=0, r_data=0, r_resp=0, r_last=0. RAM contents are not reset.
- Write path:
  - AW handshake at edge N: w_ready=1 from N+1.
  - One beat is accepted per cycle while w_valid=1.
  - Last W handshake at edge M: b_valid=1 from M+1.
  - After the B handshake, aw_ready and ar_ready may go high again in the next cycle.
- Read path:
  - AR handshake at edge N: r_valid=1 with beat 0 from N+1.
  - Back-to-back beats run at one per cycle while r_ready=1.
  - With r_ready=0, all R outputs hold stable.
- AW/AR readys are low in every non-IDLE state. No overlap between transactions.
- Read after write to the same word in a later transaction returns the new data. The RAM write commits on the W handshake edge.
- A reset assertion mid-burst forces IDLE asynchronously and drives all outputs to their reset values. The partially written RAM content is kept.

## Test plan
- Single write then read: AW addr 0x10, len 0, size 4, INCR; W data 0x0123…CDEF, strb 0xFFFF, last 1 -> b_resp 00. AR at the same address -> r_data equal to the written data, r_last 1, r_resp 00.
- INCR burst with backpressure: write len 3 from 0x100 with 4 distinct words and w_valid toggled every cycle. Read back len 3 with r_ready low every other cycle -> 4 beats in order, r_last only on the 4th beat, outputs stable while stalled.
- Strobe/narrow: write 0xFFFF…FFFF to 0x200, then write size 0 at addr 0x203 with strb 0x0008, data byte 3 = 0x5A -> read of 0x200 returns all 0xFF except byte 3 = 0x5A.
- Arbitration: AW and AR valid in the same cycle, twice in a row after reset -> first grant is write, second is read, with the write B handshake completing before ar_ready rises.
- Errors:
  - Write with len 1 from address MEM_WORDS*16-16 -> beat 1 is dropped, b_resp 10, word 0 unchanged.
  - WRAP burst read -> every beat returns data 0 with r_resp 10.
  - w_last asserted early -> b_resp 10.
- Reset mid-burst: assert reset after beat 1 of a len 3 write -> all outputs take their reset values at once. After release, aw_ready=1 in IDLE and a new transaction completes normally.
